cdb_arbiter: RTL
================

// Module: cdb_arbiter
// PURPOSE
//  Producer end of the common data bus consumed by the commit unit and reservation stations.
//  Per functional unit (FU): buffers completed results, drops squashed speculative ones.
//  Round-robin picks one result per cycle and drives it registered onto cdb_en/cdb_reg_id/cdb_iss_id/cdb_data.
// PARAMETERS
//  NUM_FU      4   number of FU result ports
//  FIFO_DEPTH  2   entries per FU queue (power of 2, >=2)
//  ISS_ID_W    8   issue-id width; zero-extended onto the 32-bit cdb_iss_id
// PORTS
//  clk                 in   1             clock
//  reset               in   1             reset, synchronous, active-high
//  fu_valid            in   NUM_FU        FU result valid, bit k = FU k
//  fu_ready            out  NUM_FU        queue k can accept this cycle
//  fu_reg_id           in   5*NUM_FU      destination reg, FU k at [5k+4:5k]
//  fu_iss_id           in   ISS_ID_W*NUM_FU  issue id of result
//  fu_data             in   32*NUM_FU     result value
//  fu_spec             in   NUM_FU        result issued under an unresolved branch
//  prediction_failed   in   1             squash all speculative results
//  prediction_success  in   1             promote all speculative results to non-speculative
//  cdb_en              out  1             broadcast valid (one cycle per result)
//  cdb_reg_id          out  5             broadcast destination reg
//  cdb_iss_id          out  32            {zeros, iss_id}
//  cdb_data            out  32            broadcast value
// BEHAVIOUR
//  Reset: all queues empty, all slot valid bits 0, rr_ptr=0, cdb_en=0, cdb_reg_id=0, cdb_iss_id=0, cdb_data=0.
//  Reset mid-operation discards all queued results.
//  Handshake: transfer when fu_valid[k]&fu_ready[k]. fu_ready[k] = queue k count < FIFO_DEPTH (combinational from count).
//  Pop in the same cycle does not raise fu_ready.
//  Queue slot = {valid, spec, reg_id, iss_id, data}. Head/tail pointers wrap modulo FIFO_DEPTH.
//  Results with reg_id==0 are accepted and never broadcast.
//  Flush (prediction_failed):
//   - every queued slot with spec=1 gets valid=0;
//   - an accepted input with fu_spec=1 that cycle is written with valid=0.
//  Promote (prediction_success): all queued spec bits cleared; an accepted input that cycle stores spec=0.
//  Both failed and success asserted: failed wins.
//  Invalid head: popped silently in one cycle and excluded from arbitration.
//  Arbitration:
//   - candidates are queues with a valid head and reg_id!=0;
//   - search starts at rr_ptr, lowest index after rr_ptr wins (wrap at NUM_FU);
//   - winner popped; rr_ptr <= (winner+1) mod NUM_FU; rr_ptr holds when there is no winner.
//  Output register:
//   - loads the winner every cycle, cdb_en=1;
//   - cdb_en=0 when there is no winner, or prediction_failed is high and the winner has spec=1 (winner still popped);
//   - cdb_reg_id, cdb_iss_id and cdb_data hold their last values when cdb_en=0.
//  Latency: handshake in cycle t -> cdb_en earliest in cycle t+2.
//  Throughput: 1 result/cycle total.
//  A result already in the output register is broadcast even if prediction_failed arrives; the commit unit invalidates it.
// CONFIGURATION
//  CDB_BYPASS_EN defined:
//   - FU k with an empty queue and fu_valid[k] (not squashed, reg_id!=0) competes directly in arbitration;
//   - if it wins, it goes straight to the output register and is not enqueued: latency t+1;
//   - if it loses, it is enqueued normally.
//  CDB_BYPASS_EN undefined: every result is enqueued; latency t+2.
// STRUCTURE
//  cdb_defs.vh: CDB_REG_W=5, CDB_ISS_W=32, CDB_DATA_W=32, slot field-slice macros (SLOT_VALID, SLOT_SPEC, SLOT_REG, SLOT_ISS, SLOT_DATA).
//  Sub-module cdb_fu_fifo: one per FU via generate. It owns the slots, pointers, count, ready, flush/promote and silent-pop of invalid heads.
//  Top level holds only the round-robin picker and the output register.
// TESTING
//  1. Reset then FU0 sends reg=5, iss=0x12, data=0xDEADBEEF at t=3 -> cdb_en only at t=5 with reg 5, iss 0x00000012, data 0xDEADBEEF (t=4 with CDB_BYPASS_EN).
//  2. All 4 FUs valid every cycle, rr_ptr=0 -> broadcast order FU0,1,2,3,0,...
//     fu_ready deasserts on each queue after 2 unbroadcast entries; no result is lost or duplicated.
//  3. FU1 queue = {non-spec iss 3, spec iss 4}, prediction_failed one cycle -> only iss 3 broadcast; fu_ready[1] returns to 1 within 2 cycles.
//  4. FU2 queue = spec iss 7, prediction_success, then prediction_failed next cycle -> iss 7 still broadcast.
//     Also: failed and success in the same cycle -> iss 7 squashed.
//  5. FU3 sends reg_id=0, iss 9 -> accepted, never broadcast.
//     Also: assert reset with 2 entries queued -> cdb_en stays 0 and all fu_ready=1 on the cycle after reset.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB widths, the per-FU queue slot layout and a slot helper.
package cdb_arbiter_pkg;
    localparam int CDB_REG_W  = 5;
    localparam int CDB_ISS_W  = 32;
    localparam int CDB_DATA_W = 32;

    // Issue id is stored already zero-extended to the bus width.
    typedef struct packed {
        logic                  valid;
        logic                  spec;
        logic [CDB_REG_W-1:0]  reg_id;
        logic [CDB_ISS_W-1:0]  iss_id;
        logic [CDB_DATA_W-1:0] data;
    } slot_t;

    // A slot is worth broadcasting only if still valid and it targets a real register.
    function automatic logic slot_live(slot_t s);
        return s.valid && (s.reg_id != '0);
    endfunction
endpackage

// File: rtl/cdb_arbiter_if.sv
// FU result ports, branch resolution inputs and the CDB broadcast outputs.
interface cdb_arbiter_if #(
    parameter int NUM_FU   = 4,
    parameter int ISS_ID_W = 8
);
    import cdb_arbiter_pkg::*;

    logic [NUM_FU-1:0]                 fu_valid;
    logic [NUM_FU-1:0]                 fu_ready;
    logic [NUM_FU-1:0][CDB_REG_W-1:0]  fu_reg_id;
    logic [NUM_FU-1:0][ISS_ID_W-1:0]   fu_iss_id;
    logic [NUM_FU-1:0][CDB_DATA_W-1:0] fu_data;
    logic [NUM_FU-1:0]                 fu_spec;
    logic                              prediction_failed;
    logic                              prediction_success;
    logic                              cdb_en;
    logic [CDB_REG_W-1:0]              cdb_reg_id;
    logic [CDB_ISS_W-1:0]              cdb_iss_id;
    logic [CDB_DATA_W-1:0]             cdb_data;

    modport master (
        output fu_valid, fu_reg_id, fu_iss_id, fu_data, fu_spec,
        output prediction_failed, prediction_success,
        input  fu_ready, cdb_en, cdb_reg_id, cdb_iss_id, cdb_data
    );

    modport slave (
        input  fu_valid, fu_reg_id, fu_iss_id, fu_data, fu_spec,
        input  prediction_failed, prediction_success,
        output fu_ready, cdb_en, cdb_reg_id, cdb_iss_id, cdb_data
    );
endinterface

// File: rtl/cdb_arbiter_fu_fifo.sv
// Per-FU result queue: squash/promote of speculative slots, silent drop of dead heads.
// Optional CDB_BYPASS_EN: an empty queue offers the incoming result as its head.
module cdb_arbiter_fu_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid_i,
    input  logic                  in_spec_i,
    input  logic [CDB_REG_W-1:0]  in_reg_i,
    input  logic [CDB_ISS_W-1:0]  in_iss_i,
    input  logic [CDB_DATA_W-1:0] in_data_i,
    input  logic                  flush_i,
    input  logic                  promote_i,
    input  logic                  pop_i,
    output logic                  ready_o,
    output logic                  cand_o,
    output slot_t                 head_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    slot_t            mem_q [DEPTH];
    slot_t            mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    slot_t            in_slot;
    logic             empty, stored_live, push, pop;

    always_comb begin
        in_slot = '{valid:  !(flush_i && in_spec_i),
                    spec:   in_spec_i && !promote_i,
                    reg_id: in_reg_i,
                    iss_id: in_iss_i,
                    data:   in_data_i};
    end

    assign empty       = (cnt_q == '0);
    assign ready_o     = (cnt_q < CNT_W'(DEPTH));
    assign stored_live = !empty && slot_live(mem_q[head_q]);

`ifdef CDB_BYPASS_EN
    logic bypass;
    assign bypass = empty && in_valid_i && slot_live(in_slot);
    assign head_o = bypass ? in_slot : mem_q[head_q];
    assign cand_o = stored_live || bypass;
    // A bypassed result that wins goes straight to the bus and is not stored.
    assign push   = in_valid_i && ready_o && !(bypass && pop_i);
`else
    assign head_o = mem_q[head_q];
    assign cand_o = stored_live;
    assign push   = in_valid_i && ready_o;
`endif

    // Dead heads (squashed or reg 0) leave without taking an arbitration slot.
    assign pop = !empty && (pop_i || !stored_live);

    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (flush_i) begin
                if (mem_q[i].spec) mem_d[i].valid = 1'b0;
            end else if (promote_i) begin
                mem_d[i].spec = 1'b0;
            end
        end
        if (push) mem_d[tail_q] = in_slot;
        tail_d = tail_q + PTR_W'(push);
        head_d = head_q + PTR_W'(pop);
        cnt_d  = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// CDB producer: per-FU queues, round-robin pick, registered broadcast.
// Optional CDB_BYPASS_EN lets an empty queue's incoming result compete directly.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU     = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int ISS_ID_W   = 8
) (
    input  logic          clk,
    input  logic          reset,
    cdb_arbiter_if.slave  bus
);
    localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0]     cand, pop, ready;
    slot_t                 head [NUM_FU];
    slot_t                 win;
    logic                  win_vld, en_d, en_q;
    logic [IDX_W-1:0]      win_idx, rr_d, rr_q;
    logic [CDB_REG_W-1:0]  reg_q;
    logic [CDB_ISS_W-1:0]  iss_q;
    logic [CDB_DATA_W-1:0] data_q;

    for (genvar k = 0; k < NUM_FU; k++) begin : g_fu
        cdb_arbiter_fu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .in_valid_i(bus.fu_valid[k]),
            .in_spec_i (bus.fu_spec[k]),
            .in_reg_i  (bus.fu_reg_id[k]),
            .in_iss_i  (CDB_ISS_W'(bus.fu_iss_id[k])),
            .in_data_i (bus.fu_data[k]),
            .flush_i   (bus.prediction_failed),
            .promote_i (bus.prediction_success),
            .pop_i     (pop[k]),
            .ready_o   (ready[k]),
            .cand_o    (cand[k]),
            .head_o    (head[k])
        );
    end

    // First candidate at or after rr_q, wrapping at NUM_FU.
    always_comb begin
        int idx;
        idx     = 0;
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            idx = (int'(rr_q) + i) % NUM_FU;
            if (!win_vld && cand[idx]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int k = 0; k < NUM_FU; k++) pop[k] = win_vld && (int'(win_idx) == k);
    end

    assign win  = head[win_idx];
    assign rr_d = !win_vld ? rr_q :
                  (int'(win_idx) == NUM_FU - 1) ? '0 : win_idx + IDX_W'(1);
    // A speculative winner caught by a flush is still popped, just not broadcast.
    assign en_d = win_vld && !(bus.prediction_failed && win.spec);

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q   <= '0;
            en_q   <= 1'b0;
            reg_q  <= '0;
            iss_q  <= '0;
            data_q <= '0;
        end else begin
            rr_q <= rr_d;
            en_q <= en_d;
            if (en_d) begin
                reg_q  <= win.reg_id;
                iss_q  <= win.iss_id;
                data_q <= win.data;
            end
        end
    end

    assign bus.fu_ready   = ready;
    assign bus.cdb_en     = en_q;
    assign bus.cdb_reg_id = reg_q;
    assign bus.cdb_iss_id = iss_q;
    assign bus.cdb_data   = data_q;
endmodule
